cardinal_nic_fifo: RTL and testbench

Parametrised successor of the single-slot cardinal NIC. It sits between a PE's memory-mapped port and one router local port. Each direction has a multi-entry FIFO instead of a one-packet buffer. It adds occupancy counters, a sticky overflow/underflow error register, a soft flush, and polarity-gated injection from the FIFO head.

---
 rtl/cardinal_nic_fifo_pkg.sv | 20 ++
 rtl/cardinal_nic_fifo_buf.sv | 80 ++++++++
 rtl/cardinal_nic_fifo.sv | 116 +++++++++++
 tb/tb_cardinal_nic_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_fifo_pkg.sv
// Shared constants for the FIFO-based cardinal NIC.
//   - PE register addresses
//   - bit positions inside CTRL and ERR
package cardinal_nic_pkg;

  localparam logic [2:0] ADDR_IN_DATA  = 3'b000;
  localparam logic [2:0] ADDR_IN_STAT  = 3'b001;
  localparam logic [2:0] ADDR_OUT_DATA = 3'b010;
  localparam logic [2:0] ADDR_OUT_STAT = 3'b011;
  localparam logic [2:0] ADDR_CTRL     = 3'b100;
  localparam logic [2:0] ADDR_ERR      = 3'b101;

  localparam int CTRL_IE        = 0;
  localparam int CTRL_FLUSH_IN  = 1;
  localparam int CTRL_FLUSH_OUT = 2;

  localparam int ERR_OVERFLOW   = 0;
  localparam int ERR_UNDERFLOW  = 1;

endpackage

// File: rtl/cardinal_nic_fifo_buf.sv
// nic_fifo: circular-buffer FIFO with occupancy count and synchronous flush.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   push, pop, flush push din / drop head / empty the FIFO (flush wins)
//   din              write data
//   dout             current head entry
//   count            number of stored entries
//   full, empty      count == DEPTH / count == 0
// A push while full or a pop while empty is ignored.
module nic_fifo
  import cardinal_nic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo: NIC between a PE memory-mapped port and a router local
// port, with a FIFO in each direction, sticky error flags, soft flush and
// polarity-gated injection.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   addr, d_in, d_out       PE register address, write data, read data
//   nicEn, nicWrEn          PE access enable, write (1) / read (0)
//   net_si, net_ri, net_di  router -> NIC handshake and packet
//   net_so, net_ro, net_do  NIC -> router handshake and packet
//   net_polarity            router polarity, gates injection by VC bit
//   irq                     registered interrupt, masked by CTRL.ie
module cardinal_nic_fifo
  import cardinal_nic_pkg::*;
#(
  parameter int PAC_WIDTH = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = $clog2(((IN_DEPTH > OUT_DEPTH) ? IN_DEPTH : OUT_DEPTH) + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           addr,
  input  logic [PAC_WIDTH-1:0] d_in,
  output logic [PAC_WIDTH-1:0] d_out,
  input  logic                 nicEn,
  input  logic                 nicWrEn,
  input  logic                 net_si,
  output logic                 net_ri,
  input  logic [PAC_WIDTH-1:0] net_di,
  output logic                 net_so,
  input  logic                 net_ro,
  output logic [PAC_WIDTH-1:0] net_do,
  input  logic                 net_polarity,
  output logic                 irq
);

  logic                 rd, wr;
  logic                 in_push, in_pop, in_flush, in_full, in_empty;
  logic                 out_push, out_pop, out_flush, out_full, out_empty;
  logic [CNT_W-1:0]     in_count, out_count;
  logic [PAC_WIDTH-1:0] in_head, out_head;
  logic                 overflow_evt, underflow_evt, vc_ok;
  logic [1:0]           err_q, err_d;
  logic                 ie_q, ie_d;
  logic                 irq_q, irq_d;

  assign rd = nicEn & ~nicWrEn;
  assign wr = nicEn & nicWrEn;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign underflow_evt = rd & (addr == ADDR_IN_DATA) & in_empty;
  assign overflow_evt  = wr & (addr == ADDR_OUT_DATA) & out_full;
  assign in_pop        = rd & (addr == ADDR_IN_DATA) & ~in_empty;
  assign out_push      = wr & (addr == ADDR_OUT_DATA) & ~out_full;
  assign in_flush      = wr & (addr == ADDR_CTRL) & d_in[CTRL_FLUSH_IN];
  assign out_flush     = wr & (addr == ADDR_CTRL) & d_in[CTRL_FLUSH_OUT];

  // Held low through reset so the router never hands over a packet that would be lost.
  assign net_ri  = reset_n & ~in_full;
  assign in_push = net_si & net_ri;

  // Only a head whose VC bit opposes the router polarity may leave; others block in order.
  assign vc_ok   = net_polarity ^ out_head[0];
  assign net_so  = ~out_empty & vc_ok;
  assign out_pop = net_so & net_ro;
  assign net_do  = out_head;
  assign irq     = irq_q;

  nic_fifo #(.WIDTH(PAC_WIDTH), .DEPTH(IN_DEPTH), .CNT_W(CNT_W)) u_in_fifo (
    .clk(clk), .reset_n(reset_n), .push(in_push), .pop(in_pop), .flush(in_flush),
    .din(net_di), .dout(in_head), .count(in_count), .full(in_full), .empty(in_empty)
  );

  nic_fifo #(.WIDTH(PAC_WIDTH), .DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk(clk), .reset_n(reset_n), .push(out_push), .pop(out_pop), .flush(out_flush),
    .din(d_in), .dout(out_head), .count(out_count), .full(out_full), .empty(out_empty)
  );

  always_comb begin
    d_out = '0;
    if (rd) begin
      case (addr)
        ADDR_IN_DATA:  d_out = in_empty ? '0 : in_head;
        ADDR_IN_STAT:  d_out = PAC_WIDTH'({in_count, in_full, in_empty});
        ADDR_OUT_STAT: d_out = PAC_WIDTH'({out_count, out_full, out_empty});
        ADDR_CTRL:     d_out = PAC_WIDTH'(ie_q);
        ADDR_ERR:      d_out = PAC_WIDTH'(err_q);
        default:       d_out = '0;
      endcase
    end
  end

  // An error event beats a same-cycle clear, so the clear comes first.
  always_comb begin
    err_d = err_q;
    ie_d  = ie_q;
    if (wr && addr == ADDR_ERR)  err_d = '0;
    if (overflow_evt)            err_d[ERR_OVERFLOW]  = 1'b1;
    if (underflow_evt)           err_d[ERR_UNDERFLOW] = 1'b1;
    if (wr && addr == ADDR_CTRL) ie_d = d_in[CTRL_IE];
    irq_d = ie_q & (~in_empty | (err_q != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      err_q <= err_d;
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
module tb_cardinal_nic_fifo;

  logic        clk, reset_n;
  logic [2:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity, irq;

  int checks = 0;
  int errors = 0;
  logic [63:0] in_q[$];
  logic [63:0] out_q[$];

  cardinal_nic_fifo dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pe_read(input logic [2:0] a, output logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1 v = d_out;
    @(posedge clk); #1;
    nicEn = 1'b0;
  endtask

  task automatic pe_write(input logic [2:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    @(posedge clk); #1;
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  function automatic logic [63:0] in_pkt(input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 4) | 64'(i & 1);
  endfunction

  function automatic logic [63:0] out_pkt(input int i);
    return 64'h0000_C0DE_0000_0000 | (64'(i) << 8) | ((i == 0) ? 64'd1 : 64'(i & 1));
  endfunction

  task automatic test_reset();
    logic [63:0] v;
    reset_n = 1'b0; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
    net_si = 0; net_di = 0; net_ro = 0; net_polarity = 0;
    tick(); tick();
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL reset_ri_low: got %b want 0", net_ri); end
    #2 reset_n = 1'b1;
    tick();
    pe_read(3'b001, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL reset_in_stat: got %h want 1", v); end
    pe_read(3'b011, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL reset_out_stat: got %h want 1", v); end
    checks++; if ({net_ri, net_so, irq} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got ri/so/irq=%b want 100", {net_ri, net_so, irq});
    end
  endtask

  task automatic test_in_fill();
    logic [63:0] v;
    int accepted = 0;
    net_si = 1'b1; net_di = in_pkt(0);
    for (int c = 0; c < 20 && accepted < 4; c++) begin
      if (net_ri) begin in_q.push_back(net_di); accepted++; end
      tick();
      net_di = in_pkt(accepted);
    end
    checks++; if (accepted != 4) begin errors++; $display("FAIL fill_accepted: got %0d want 4", accepted); end
    tick(); tick();
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL fill_ri: got %b want 0", net_ri); end
    pe_read(3'b001, v);
    checks++; if (v !== 64'h12) begin errors++; $display("FAIL fill_in_stat: got %h want 12", v); end
    pe_read(3'b000, v);
    checks++; if (v !== in_q[0]) begin errors++; $display("FAIL fill_pop: got %h want %h", v, in_q[0]); end
    void'(in_q.pop_front());
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL fill_ri_reopen: got %b want 1", net_ri); end
    in_q.push_back(net_di);
    tick();
    net_si = 1'b0;
    while (in_q.size() > 0) begin
      pe_read(3'b000, v);
      checks++; if (v !== in_q[0]) begin errors++; $display("FAIL fill_drain: got %h want %h", v, in_q[0]); end
      void'(in_q.pop_front());
    end
    pe_read(3'b001, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL fill_in_stat_empty: got %h want 1", v); end
  endtask

  task automatic test_out_overflow();
    logic [63:0] v;
    net_ro = 1'b0; net_polarity = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) out_q.push_back(out_pkt(i));
      pe_write(3'b010, out_pkt(i));
    end
    pe_read(3'b011, v);
    checks++; if (v !== 64'h12) begin errors++; $display("FAIL ovf_out_stat: got %h want 12", v); end
    pe_read(3'b101, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL ovf_err: got %h want 1", v); end
    pe_write(3'b101, 64'h0);
    pe_read(3'b101, v);
    checks++; if (v !== 64'h0) begin errors++; $display("FAIL ovf_err_clear: got %h want 0", v); end
  endtask

  task automatic test_vc_gate();
    logic [63:0] v;
    net_polarity = 1'b1; net_ro = 1'b1;
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL vc_blocked_so: got %b want 0", net_so); end
    tick();
    net_ro = 1'b0;
    pe_read(3'b011, v);
    checks++; if (v !== 64'h12) begin errors++; $display("FAIL vc_blocked_count: got %h want 12", v); end
    net_polarity = 1'b0; net_ro = 1'b1;
    #1;
    checks++; if (net_so !== 1'b1 || net_do !== out_q[0]) begin
      errors++; $display("FAIL vc_release: got so=%b do=%h want so=1 do=%h", net_so, net_do, out_q[0]);
    end
    tick();
    void'(out_q.pop_front());
    net_ro = 1'b0;
    pe_read(3'b011, v);
    checks++; if (v !== 64'h0C) begin errors++; $display("FAIL vc_count_dec: got %h want 0c", v); end
    net_ro = 1'b1;
    for (int c = 0; c < 20 && out_q.size() > 0; c++) begin
      net_polarity = ~out_q[0][0];
      #1;
      checks++; if (net_so !== 1'b1 || net_do !== out_q[0]) begin
        errors++; $display("FAIL vc_drain: got so=%b do=%h want so=1 do=%h", net_so, net_do, out_q[0]);
      end
      tick();
      void'(out_q.pop_front());
    end
    net_ro = 1'b0;
    pe_read(3'b011, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL vc_out_empty: got %h want 1", v); end
  endtask

  task automatic test_underflow_irq();
    logic [63:0] v;
    pe_write(3'b100, 64'h1);
    pe_read(3'b000, v);
    checks++; if (v !== 64'h0) begin errors++; $display("FAIL udf_data: got %h want 0", v); end
    pe_read(3'b101, v);
    checks++; if (v !== 64'h2) begin errors++; $display("FAIL udf_err: got %h want 2", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL udf_irq: got %b want 1", irq); end
    pe_read(3'b100, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL ctrl_read: got %h want 1", v); end
    pe_write(3'b101, 64'h0);
    pe_write(3'b100, 64'h0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    net_si = 1'b1;
    for (int i = 0; i < 2; i++) begin
      net_di = in_pkt(10 + i); in_q.push_back(net_di); tick();
    end
    for (int i = 0; i < 3; i++) begin
      net_di = in_pkt(20 + i);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 3'b000;
      #1;
      checks++; if (d_out !== in_q[0]) begin errors++; $display("FAIL b2b_pop: got %h want %h", d_out, in_q[0]); end
      void'(in_q.pop_front());
      in_q.push_back(net_di);
      tick();
    end
    net_si = 1'b0; nicEn = 1'b0;
    pe_read(3'b001, v);
    checks++; if (v !== 64'h08) begin errors++; $display("FAIL b2b_count: got %h want 08", v); end
    while (in_q.size() > 0) begin
      pe_read(3'b000, v);
      checks++; if (v !== in_q[0]) begin errors++; $display("FAIL b2b_order: got %h want %h", v, in_q[0]); end
      void'(in_q.pop_front());
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] v;
    pe_write(3'b100, 64'h1);
    net_si = 1'b1;
    for (int i = 0; i < 2; i++) begin net_di = in_pkt(30 + i); tick(); end
    net_si = 1'b0; net_ro = 1'b0; net_polarity = 1'b0;
    pe_write(3'b010, 64'h10);
    pe_write(3'b010, 64'h21);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst_irq_before: got %b want 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({net_ri, net_so, irq} !== 3'b000) begin
      errors++; $display("FAIL arst_flags: got ri/so/irq=%b want 000", {net_ri, net_so, irq});
    end
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 3'b001;
    #1;
    checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL arst_in_stat: got %h want 1", d_out); end
    nicEn = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    tick();
    pe_read(3'b011, v);
    checks++; if (v !== 64'h1) begin errors++; $display("FAIL arst_out_stat: got %h want 1", v); end
    pe_read(3'b100, v);
    checks++; if (v !== 64'h0) begin errors++; $display("FAIL arst_ctrl: got %h want 0", v); end
    pe_read(3'b101, v);
    checks++; if (v !== 64'h0) begin errors++; $display("FAIL arst_err: got %h want 0", v); end
    in_q.delete(); out_q.delete();
  endtask

  initial begin
    test_reset();
    test_in_fill();
    test_out_overflow();
    test_vc_gate();
    test_underflow_irq();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
